// File: rtl/apb_host_bridge.sv
// APB master bridge: turns a valid/ready host command into APB SETUP/ACCESS
// cycles with one-hot slave decode, wait-state timeout and a one-cycle response.
module apb_host_bridge #(
  parameter int unsigned NUM_SLAVES     = 16,
  parameter int unsigned SEL_LSB        = 12,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_timeout,
  output logic        rsp_decerr,
  output logic [15:0] PADDR,
  output logic [15:0] PWDATA,
  output logic        PWRITE,
  output logic [15:0] PSEL,
  output logic        PENABLE,
  input  logic [15:0] PRDATA,
  input  logic        PREADY
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYCLES);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  logic [1:0]       r_state,       w_state_nxt;
  logic [CNT_W-1:0] r_wait_cnt,    w_wait_cnt_nxt;
  logic             r_req_ready,   w_req_ready_nxt;
  logic [15:0]      r_paddr,       w_paddr_nxt;
  logic [15:0]      r_pwdata,      w_pwdata_nxt;
  logic             r_pwrite,      w_pwrite_nxt;
  logic [15:0]      r_psel,        w_psel_nxt;
  logic             r_penable,     w_penable_nxt;
  logic             r_rsp_valid,   w_rsp_valid_nxt;
  logic [15:0]      r_rsp_rdata,   w_rsp_rdata_nxt;
  logic             r_rsp_timeout, w_rsp_timeout_nxt;
  logic             r_rsp_decerr,  w_rsp_decerr_nxt;

  logic [3:0]       w_idx;
  logic             w_idx_ok;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_timeout_hit;

  assign w_idx         = req_addr[SEL_LSB +: 4];
  assign w_idx_ok      = (32'(w_idx) < NUM_SLAVES);
  assign w_cnt_inc     = (r_wait_cnt == CNT_MAX) ? r_wait_cnt : r_wait_cnt + CNT_W'(1);
  assign w_timeout_hit = (TIMEOUT_CYCLES != 0) && (w_cnt_inc == CNT_LIM);

  // Next-state and next-output decode; response fields default to a cleared pulse.
  always_comb begin
    w_state_nxt       = r_state;
    w_wait_cnt_nxt    = r_wait_cnt;
    w_paddr_nxt       = r_paddr;
    w_pwdata_nxt      = r_pwdata;
    w_pwrite_nxt      = r_pwrite;
    w_psel_nxt        = r_psel;
    w_penable_nxt     = r_penable;
    w_rsp_valid_nxt   = 1'b0;
    w_rsp_rdata_nxt   = 16'd0;
    w_rsp_timeout_nxt = 1'b0;
    w_rsp_decerr_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid && r_req_ready) begin
          w_paddr_nxt   = req_addr;
          w_pwdata_nxt  = req_wdata;
          w_pwrite_nxt  = req_write;
          w_penable_nxt = 1'b0;
          if (w_idx_ok) begin
            w_psel_nxt  = 16'd1 << w_idx;
            w_state_nxt = SETUP;
          end else begin
            w_psel_nxt       = 16'd0;
            w_rsp_valid_nxt  = 1'b1;
            w_rsp_decerr_nxt = 1'b1;
          end
        end
      end
      SETUP: begin
        w_penable_nxt = 1'b1;
        w_state_nxt   = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          w_psel_nxt      = 16'd0;
          w_penable_nxt   = 1'b0;
          w_wait_cnt_nxt  = '0;
          w_state_nxt     = IDLE;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_rdata_nxt = r_pwrite ? 16'd0 : PRDATA;
        end else if (w_timeout_hit) begin
          w_psel_nxt        = 16'd0;
          w_penable_nxt     = 1'b0;
          w_wait_cnt_nxt    = '0;
          w_state_nxt       = IDLE;
          w_rsp_valid_nxt   = 1'b1;
          w_rsp_timeout_nxt = 1'b1;
        end else begin
          w_wait_cnt_nxt = w_cnt_inc;
        end
      end
      default: begin
        w_psel_nxt     = 16'd0;
        w_penable_nxt  = 1'b0;
        w_wait_cnt_nxt = '0;
        w_state_nxt    = IDLE;
      end
    endcase
    w_req_ready_nxt = (w_state_nxt == IDLE);
  end

  // State and registered outputs; reset drops the bus immediately.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state       <= IDLE;
      r_wait_cnt    <= '0;
      r_req_ready   <= 1'b1;
      r_paddr       <= 16'd0;
      r_pwdata      <= 16'd0;
      r_pwrite      <= 1'b0;
      r_psel        <= 16'd0;
      r_penable     <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= 16'd0;
      r_rsp_timeout <= 1'b0;
      r_rsp_decerr  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_wait_cnt    <= w_wait_cnt_nxt;
      r_req_ready   <= w_req_ready_nxt;
      r_paddr       <= w_paddr_nxt;
      r_pwdata      <= w_pwdata_nxt;
      r_pwrite      <= w_pwrite_nxt;
      r_psel        <= w_psel_nxt;
      r_penable     <= w_penable_nxt;
      r_rsp_valid   <= w_rsp_valid_nxt;
      r_rsp_rdata   <= w_rsp_rdata_nxt;
      r_rsp_timeout <= w_rsp_timeout_nxt;
      r_rsp_decerr  <= w_rsp_decerr_nxt;
    end
  end

  assign req_ready   = r_req_ready;
  assign PADDR       = r_paddr;
  assign PWDATA      = r_pwdata;
  assign PWRITE      = r_pwrite;
  assign PSEL        = r_psel;
  assign PENABLE     = r_penable;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_timeout = r_rsp_timeout;
  assign rsp_decerr  = r_rsp_decerr;

endmodule

// File: tb/tb_apb_host_bridge.sv
// Bench for apb_host_bridge: a transaction-level timeline model checked every
// cycle, plus literal per-command expectations on select, latency and response.
module tb_apb_host_bridge;

  localparam int NS   = 4;
  localparam int TO   = 8;
  localparam int MAXC = 512;

  logic        PCLK, PRESETn;
  logic        req_valid, req_ready, req_write;
  logic [15:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_timeout, rsp_decerr;
  logic [15:0] rsp_rdata;
  logic [15:0] PADDR, PWDATA, PSEL, PRDATA;
  logic        PWRITE, PENABLE, PREADY;

  apb_host_bridge #(
    .NUM_SLAVES    (NS),
    .SEL_LSB       (12),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_timeout(rsp_timeout),
    .rsp_decerr (rsp_decerr),
    .PADDR      (PADDR),
    .PWDATA     (PWDATA),
    .PWRITE     (PWRITE),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PRDATA     (PRDATA),
    .PREADY     (PREADY)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  logic chk_en = 1'b0;
  always @(posedge PCLK) cyc <= cyc + 1;

  // Expected output timeline, one entry per clock cycle.
  logic        m_ready [MAXC];
  logic [15:0] m_psel  [MAXC];
  logic        m_pen   [MAXC];
  logic        m_pwrite[MAXC];
  logic [15:0] m_paddr [MAXC];
  logic [15:0] m_pwdata[MAXC];
  logic        m_rv    [MAXC];
  logic [15:0] m_rd    [MAXC];
  logic        m_to    [MAXC];
  logic        m_de    [MAXC];

  function automatic void model_reset(input int from);
    for (int k = from; k < MAXC; k++) begin
      m_ready[k] = 1'b1; m_psel[k] = 16'h0; m_pen[k] = 1'b0; m_pwrite[k] = 1'b0;
      m_paddr[k] = 16'h0; m_pwdata[k] = 16'h0; m_rv[k] = 1'b0; m_rd[k] = 16'h0;
      m_to[k] = 1'b0; m_de[k] = 1'b0;
    end
  endfunction

  // Command accepted at the edge ending cycle c; waits = ACCESS cycles with PREADY low.
  function automatic void model_cmd(input int c, input logic wr, input logic [15:0] addr,
                                    input logic [15:0] wdata, input int waits,
                                    input logic [15:0] prd);
    int idx, a, r;
    logic to;
    idx = int'(addr[15:12]);
    for (int k = c + 1; k < MAXC; k++) begin
      m_paddr[k] = addr; m_pwdata[k] = wdata; m_pwrite[k] = wr;
    end
    if (idx >= NS) begin
      m_rv[c+1] = 1'b1;
      m_de[c+1] = 1'b1;
      return;
    end
    to = (waits >= TO);
    a  = to ? TO : waits + 1;
    r  = c + 2 + a;
    for (int k = c + 1; k < r; k++) begin
      m_ready[k] = 1'b0;
      m_psel[k]  = 16'(1) << idx;
      m_pen[k]   = (k >= c + 2);
    end
    m_rv[r] = 1'b1;
    m_to[r] = to;
    m_rd[r] = (!wr && !to) ? prd : 16'h0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every-cycle comparison against the model, sampled mid-cycle.
  always @(negedge PCLK) begin
    if (chk_en && cyc < MAXC) begin
      logic [69:0] exp_v, act_v;
      exp_v = {m_ready[cyc], m_psel[cyc], m_pen[cyc], m_pwrite[cyc], m_paddr[cyc],
               m_pwdata[cyc], m_rv[cyc], m_rd[cyc], m_to[cyc], m_de[cyc]};
      act_v = {req_ready, PSEL, PENABLE, PWRITE, PADDR, PWDATA,
               rsp_valid, rsp_rdata, rsp_timeout, rsp_decerr};
      n_checks++;
      if (act_v !== exp_v) begin
        n_errors++;
        $display("FAIL cycle_%0d {rdy,psel,pen,pwr,paddr,pwdata,rv,rdata,to,de}: got %h expected %h",
                 cyc, act_v, exp_v);
      end
    end
  end

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Issue one command and drive the slave side; returns in the response cycle.
  task automatic do_cmd(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                        input int waits, input logic [15:0] prd, input logic hold,
                        input logic [15:0] lit_psel, input int lit_lat,
                        input logic [15:0] lit_rd, input logic lit_to, input logic lit_de);
    int c, a;
    c = cyc;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    PREADY = (waits == 0); PRDATA = 16'hDEAD;
    model_cmd(c, wr, addr, wdata, waits, prd);
    tick();
    if (hold) begin
      req_addr = ~addr; req_wdata = ~wdata; req_write = ~wr;
    end else begin
      req_valid = 1'b0;
    end
    check("psel_setup", 32'(PSEL), 32'(lit_psel));
    if (int'(addr[15:12]) < NS) begin
      tick();
      a = (waits >= TO) ? TO : waits + 1;
      for (int j = 0; j < a; j++) begin
        PREADY = (j == waits);
        PRDATA = (j == waits) ? prd : 16'hDEAD;
        tick();
      end
      PREADY = 1'b0; PRDATA = 16'hDEAD;
    end
    check("latency",     32'(cyc - c),       32'(lit_lat));
    check("rsp_valid",   32'(rsp_valid),     32'h1);
    check("rsp_rdata",   32'(rsp_rdata),     32'(lit_rd));
    check("rsp_timeout", 32'(rsp_timeout),   32'(lit_to));
    check("rsp_decerr",  32'(rsp_decerr),    32'(lit_de));
  endtask

  initial begin
    int c;
    model_reset(0);
    PRESETn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 16'h0; req_wdata = 16'h0;
    PREADY = 1'b0; PRDATA = 16'hDEAD;
    chk_en = 1'b1;
    tick(); tick();
    check("reset_psel", 32'(PSEL), 32'h0);
    check("reset_ready", 32'(req_ready), 32'h1);
    PRESETn = 1'b1;
    tick(); tick();

    // Zero-wait write to slave 1; write returns rdata 0 regardless of PRDATA.
    do_cmd(1'b1, 16'h1004, 16'hA5A5, 0, 16'h5555, 1'b0, 16'h0002, 3, 16'h0, 1'b0, 1'b0);
    check("pwrite_hold", 32'(PWRITE), 32'h1);
    check("paddr_hold",  32'(PADDR),  32'h1004);
    tick();
    // Read with three wait states.
    do_cmd(1'b0, 16'h0010, 16'h0000, 3, 16'h1234, 1'b0, 16'h0001, 6, 16'h1234, 1'b0, 1'b0);
    tick();
    // Decode error, then highest valid slave and first invalid index back-to-back.
    do_cmd(1'b0, 16'h5000, 16'h0000, 0, 16'h9999, 1'b0, 16'h0000, 1, 16'h0, 1'b0, 1'b1);
    do_cmd(1'b0, 16'h3FFE, 16'h0000, 0, 16'hBEEF, 1'b0, 16'h0008, 3, 16'hBEEF, 1'b0, 1'b0);
    do_cmd(1'b1, 16'h4000, 16'h7E57, 0, 16'h0000, 1'b0, 16'h0000, 1, 16'h0, 1'b0, 1'b1);
    tick();
    // Seven waits complete just before the limit; twenty waits abort at eight.
    do_cmd(1'b0, 16'h2002, 16'h0000, 7,  16'hC0DE, 1'b0, 16'h0004, 10, 16'hC0DE, 1'b0, 1'b0);
    do_cmd(1'b0, 16'h2000, 16'h0000, 20, 16'hFACE, 1'b0, 16'h0004, 10, 16'h0,    1'b1, 1'b0);
    check("to_ready", 32'(req_ready), 32'h1);
    check("to_psel",  32'(PSEL),      32'h0);
    tick();
    // req_valid held high across four zero-wait commands.
    do_cmd(1'b1, 16'h0100, 16'h1111, 0, 16'h0000, 1'b1, 16'h0001, 3, 16'h0,    1'b0, 1'b0);
    do_cmd(1'b0, 16'h1200, 16'h0000, 0, 16'h2222, 1'b1, 16'h0002, 3, 16'h2222, 1'b0, 1'b0);
    do_cmd(1'b1, 16'h2300, 16'h3333, 0, 16'h0000, 1'b1, 16'h0004, 3, 16'h0,    1'b0, 1'b0);
    do_cmd(1'b0, 16'h3400, 16'h0000, 0, 16'h4444, 1'b0, 16'h0008, 3, 16'h4444, 1'b0, 1'b0);
    tick();

    // Reset pulled low in the third ACCESS cycle of a stalled read.
    c = cyc;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h1008; req_wdata = 16'h0;
    PREADY = 1'b0; PRDATA = 16'hDEAD;
    model_cmd(c, 1'b0, 16'h1008, 16'h0, 100, 16'h7777);
    tick();
    req_valid = 1'b0;
    tick(); tick(); tick();
    check("pre_rst_penable", 32'(PENABLE), 32'h1);
    PRESETn = 1'b0;
    model_reset(cyc);
    #1;
    check("rst_psel",    32'(PSEL),    32'h0);
    check("rst_penable", 32'(PENABLE), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_no_rsp", 32'(rsp_valid), 32'h0);
    end
    PRESETn = 1'b1;
    tick();
    // A stale wait count would abort this six-wait read early.
    do_cmd(1'b0, 16'h1008, 16'h0000, 6, 16'h8888, 1'b0, 16'h0002, 9, 16'h8888, 1'b0, 1'b0);
    tick(); tick(); tick();
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
